// File: rtl/hilo_unit.sv
// hilo_unit: sequences one divide or multiply at a time on the shared
// arithmetic units, holds the architectural HI/LO registers, and reports
// divide-by-zero and watchdog aborts to the exception logic.
module hilo_unit #(
  parameter int TIMEOUT_CYC = 48,
  parameter int DRAIN_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_A,
  input  logic [31:0] value_B,
  input  logic        divStart,
  input  logic        multStart,
  input  logic        mtHi,
  input  logic        mtLo,
  output logic        divInit,
  input  logic        divStop,
  input  logic        divZero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        multInit,
  input  logic        multStop,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        divZeroErr,
  output logic        timeoutErr
);

  // Drain counter only needs to reach DRAIN_CYC; keep at least one bit.
  localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC);
  // Watchdog fires at the end of the TIMEOUT_CYC-th run cycle.
  localparam logic [5:0] WD_LAST = 6'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    MULT_RUN = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t        state_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [5:0]    wd_q;
  logic [DW-1:0] drain_q;
  logic          div_init_q;
  logic          mult_init_q;
  logic          busy_q;
  logic          done_q;
  logic          div_zero_err_q;
  logic          timeout_err_q;

  // value_B is consumed directly by the arithmetic units; it is part of this
  // port list only so the sequencer sits cleanly between control and datapath.
  logic unused_ok;
  assign unused_ok = ^value_B;

  // Sequencer FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hi_q           <= '0;
      lo_q           <= '0;
      wd_q           <= '0;
      drain_q        <= '0;
      div_init_q     <= 1'b0;
      mult_init_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      div_zero_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      div_zero_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Moves to HI/LO land first; a start in the same cycle still launches.
          if (mtHi) hi_q <= value_A;
          if (mtLo) lo_q <= value_A;
          wd_q    <= '0;
          drain_q <= '0;
          if (divStart) begin
            state_q    <= DIV_RUN;
            div_init_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (multStart) begin
            state_q     <= MULT_RUN;
            mult_init_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        DIV_RUN: begin
          // Divide-by-zero outranks a simultaneous done and skips the drain.
          if (divZero) begin
            div_zero_err_q <= 1'b1;
            state_q        <= IDLE;
            div_init_q     <= 1'b0;
            busy_q         <= 1'b0;
          end else if (divStop) begin
            hi_q    <= div_hi;
            lo_q    <= div_lo;
            done_q  <= 1'b1;
            drain_q <= '0;
            state_q <= DRAIN;
          end else if (wd_q == WD_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
            div_init_q    <= 1'b0;
            busy_q        <= 1'b0;
          end else begin
            wd_q <= wd_q + 6'd1;
          end
        end
        MULT_RUN: begin
          if (multStop) begin
            hi_q        <= mult_hi;
            lo_q        <= mult_lo;
            done_q      <= 1'b1;
            state_q     <= IDLE;
            mult_init_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
            mult_init_q   <= 1'b0;
            busy_q        <= 1'b0;
          end else begin
            wd_q <= wd_q + 6'd1;
          end
        end
        DRAIN: begin
          // divInit stays up through the done cycle plus DRAIN_CYC more so the
          // divider can clear its finish flags; late divStop is ignored here.
          if (drain_q == DRAIN_LAST) begin
            state_q    <= IDLE;
            div_init_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          div_init_q  <= 1'b0;
          mult_init_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign divInit    = div_init_q;
  assign multInit   = mult_init_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign divZeroErr = div_zero_err_q;
  assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed vectors for hilo_unit; the bench plays the role of
// the divider/multiplier by driving the done/zero pulses and result words.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value_A, value_B;
  logic        divStart, multStart, mtHi, mtLo;
  logic        divInit, divStop, divZero;
  logic [31:0] div_hi, div_lo;
  logic        multInit, multStop;
  logic [31:0] mult_hi, mult_lo;
  logic [31:0] hi, lo;
  logic        busy, done, divZeroErr, timeoutErr;

  int total = 0;
  int bad   = 0;

  hilo_unit #(.TIMEOUT_CYC(48), .DRAIN_CYC(2)) dut (
    .clk(clk), .reset(reset), .value_A(value_A), .value_B(value_B),
    .divStart(divStart), .multStart(multStart), .mtHi(mtHi), .mtLo(mtLo),
    .divInit(divInit), .divStop(divStop), .divZero(divZero),
    .div_hi(div_hi), .div_lo(div_lo),
    .multInit(multInit), .multStop(multStop),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done),
    .divZeroErr(divZeroErr), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  // Flag vector order: {busy, divInit, multInit, done, divZeroErr, timeoutErr}
  function automatic logic [31:0] flags();
    return {26'd0, busy, divInit, multInit, done, divZeroErr, timeoutErr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; value_A = '0; value_B = '0;
    divStart = 0; multStart = 0; mtHi = 0; mtLo = 0;
    divStop = 0; divZero = 0; div_hi = '0; div_lo = '0;
    multStop = 0; mult_hi = '0; mult_lo = '0;
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_flags", flags(), 32'h00);

    // Divide 100/7: remainder 2, quotient 14.
    value_A = 32'd100; value_B = 32'd7; divStart = 1;
    step(); divStart = 0;
    chk("div_start_flags", flags(), 32'h30);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("div_run_flags", flags(), 32'h30);
    end
    divStop = 1; div_hi = 32'd2; div_lo = 32'd14;
    step(); divStop = 0;
    chk("div_done_hi", hi, 32'd2);
    chk("div_done_lo", lo, 32'd14);
    chk("div_done_flags", flags(), 32'h34);
    // Late divStop during drain must not touch HI/LO.
    divStop = 1; div_hi = 32'd99; div_lo = 32'd99;
    step(); divStop = 0;
    chk("drain1_flags", flags(), 32'h30);
    step();
    chk("drain2_flags", flags(), 32'h30);
    chk("drain_late_hi", hi, 32'd2);
    chk("drain_late_lo", lo, 32'd14);
    step();
    chk("div_idle_flags", flags(), 32'h00);

    // Divide by zero, with a simultaneous divStop that must lose.
    value_B = 32'd0; divStart = 1;
    step(); divStart = 0;
    chk("dz_start_flags", flags(), 32'h30);
    step();
    divZero = 1; divStop = 1; div_hi = 32'd5; div_lo = 32'd5;
    step(); divZero = 0; divStop = 0;
    chk("dz_err_flags", flags(), 32'h02);
    chk("dz_hi_kept", hi, 32'd2);
    chk("dz_lo_kept", lo, 32'd14);
    step();
    chk("dz_after_flags", flags(), 32'h00);

    // Multiply, then a zero-bubble divide start.
    multStart = 1;
    step(); multStart = 0;
    chk("mul_start_flags", flags(), 32'h28);
    step();
    multStop = 1; mult_hi = 32'h0000_0001; mult_lo = 32'hFFFF_FFFE;
    step(); multStop = 0;
    chk("mul_hi", hi, 32'h0000_0001);
    chk("mul_lo", lo, 32'hFFFF_FFFE);
    chk("mul_done_flags", flags(), 32'h04);
    divStart = 1;
    step(); divStart = 0;
    // This cycle is the first with divInit high; the divider never finishes.
    chk("b2b_div_flags", flags(), 32'h30);
    for (int i = 2; i <= 48; i++) begin
      step();
      chk("wd_run_flags", flags(), 32'h30);
    end
    step();
    chk("wd_abort_flags", flags(), 32'h01);
    chk("wd_hi_kept", hi, 32'h0000_0001);
    chk("wd_lo_kept", lo, 32'hFFFF_FFFE);
    step();
    chk("wd_after_flags", flags(), 32'h00);

    // Moves to HI/LO in IDLE.
    mtHi = 1; mtLo = 1; value_A = 32'hDEAD_BEEF;
    step(); mtHi = 0; mtLo = 0;
    chk("mt_both_hi", hi, 32'hDEAD_BEEF);
    chk("mt_both_lo", lo, 32'hDEAD_BEEF);
    mtHi = 1; value_A = 32'h1234_5678;
    step(); mtHi = 0;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'hDEAD_BEEF);
    // Move and start in the same cycle: both happen.
    mtLo = 1; divStart = 1; value_A = 32'hCAFE_F00D;
    step(); mtLo = 0; divStart = 0;
    chk("mt_start_lo", lo, 32'hCAFE_F00D);
    chk("mt_start_flags", flags(), 32'h30);
    // Moves during DIV_RUN are ignored.
    mtHi = 1; mtLo = 1; value_A = 32'h1111_1111;
    step(); mtHi = 0; mtLo = 0;
    chk("mt_run_hi", hi, 32'h1234_5678);
    chk("mt_run_lo", lo, 32'hCAFE_F00D);
    // Reset mid-run aborts and clears HI/LO.
    reset = 1;
    step(); reset = 0;
    chk("rst_run_hi", hi, 32'h0);
    chk("rst_run_lo", lo, 32'h0);
    chk("rst_run_flags", flags(), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
